key_debounce: RTL



---
 rtl/key_pkg.sv | 29 ++
 rtl/key_debounce_ch.sv | 115 +++++++++++
 rtl/key_debounce.sv | 46 ++++
 3 files changed

// File: rtl/key_pkg.sv
// ============================================================================
// Module      : key_pkg
// Description : Shared types and constants for the key debounce block.
//               Holds the per-key FSM state encoding and the debounce window
//               defaults (hardware and simulation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  // Per-key debounce state. The encoding is fixed so that bit 1 reflects the
  // side of the window the key sits on (0 = released side, 1 = pressed side).
  typedef enum logic [1:0] {
    UP        = 2'b00,
    WAIT_DOWN = 2'b01,
    DOWN      = 2'b10,
    WAIT_UP   = 2'b11
  } key_state_t;

  // 20 ms of stable level at 50 MHz.
  localparam int DEBOUNCE_DEFAULT = 1000000;

  // Short window used for simulation so tests run in a few hundred cycles.
  localparam int DEBOUNCE_SIM = 16;

endpackage : key_pkg

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ============================================================================
// Module      : key_debounce_ch
// Description : Single-key debounce channel: 2-flop synchronizer, stability
//               counter and 4-state acceptance FSM with registered outputs.
// Ports       : clk         - system clock, rising edge
//               rst         - asynchronous active-high reset
//               key_raw     - raw button pin, active-low, asynchronous
//               key_level   - debounced level, active-low (1 = released)
//               key_press   - one-cycle pulse on accepted press (1->0)
//               key_release - one-cycle pulse on accepted release (0->1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1, so clog2 is exact.
  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Synchronizer resets to the released level so reset never looks like a
  // press edge to the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // The first new-level sample already counts as 1, so acceptance happens on
  // the DEBOUNCE_CYCLES-th consecutive sample of the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UP;
      cnt         <= '0;
      key_level   <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        UP: begin
          if (!sync2) begin
            state <= WAIT_DOWN;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_DOWN: begin
          if (sync2) begin
            state <= UP;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= DOWN;
            cnt       <= '0;
            key_level <= 1'b0;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DOWN: begin
          if (sync2) begin
            state <= WAIT_UP;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_UP: begin
          if (!sync2) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= UP;
            cnt         <= '0;
            key_level   <= 1'b1;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : key_debounce_ch

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Multi-key debounce front end. One independent channel per
//               key; all channels share clock and reset only.
// Ports       : clk         - system clock, rising edge
//               rst         - asynchronous active-high reset
//               key_raw     - [NUM_KEYS] raw pins, active-low, asynchronous
//               key_level   - [NUM_KEYS] debounced levels, active-low
//               key_press   - [NUM_KEYS] one-cycle press pulses
//               key_release - [NUM_KEYS] one-cycle release pulses
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw[i]),
        .key_level  (key_level[i]),
        .key_press  (key_press[i]),
        .key_release(key_release[i])
      );
    end
  endgenerate

endmodule : key_debounce

`default_nettype wire
